team_06_i2s_rx: RTL
===================

Name: team_06_i2s_rx

Overview:
I2S receiver that deserialises one channel of a MEMS microphone's I2S stream into 8-bit offset-binary samples. It produces the `audio_in` sample and the one-cycle `finished` strobe consumed by the audio effect stage. It runs entirely in the system `clk` domain and oversamples the external I2S pins. `clk` must be at least 8x the `i2s_sck` frequency.

Parameters:
- DATA_BITS, 24, significant bits per word transmitted MSB-first by the mic; legal range 8..32.
- CHANNEL, 0, captured slot: 0 = left (ws low), 1 = right (ws high).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- i2s_sck  input  1  I2S bit clock from pin, asynchronous to clk
- i2s_ws  input  1  I2S word select from pin, asynchronous
- i2s_sd  input  1  I2S serial data from pin, asynchronous
- en  input  1  receiver enable from FSM
- sample_out  output  8  latest captured sample, offset binary (128 = silence); feeds audio_in
- finished  output  1  one-clk pulse, new sample_out valid; feeds finished
- frame_err  output  1  one-clk pulse, word truncated by an early ws change

Behaviour:
Reset:
- Reset is asynchronous and active-high on rst; clock is clk.
- On reset: sample_out = 8'd128, finished = 0, frame_err = 0, state = IDLE, bit counter = 0, shift register = 0, all sync flops = 0.

Synchronisation:
- sck, ws and sd each pass through a 2-flop synchroniser.
- An sck rising edge ("tick") is detected when the synchronised sck is 1 and its previous registered value was 0.
- ws and sd are sampled only on a tick.
- `ws_prev` holds ws from the previous tick.
- `ws_edge` means the ws sampled on this tick differs from `ws_prev`.

State machine (all transitions occur on a tick):
- IDLE: wait for a `ws_edge` whose new ws == CHANNEL. The sd bit on that tick is the previous word's LSB and is discarded. Clear counter, go to SHIFT. Never start mid-slot.
- SHIFT: on each tick without `ws_edge`, shift sd into the LSB of the shift register and increment the counter. When the counter reaches DATA_BITS, latch the result, go to WAIT.
- SHIFT, `ws_edge` before DATA_BITS bits: discard the word, pulse frame_err, go to WAIT. sample_out is unchanged and finished stays 0.
- WAIT: ignore trailing slot bits and the other channel's slot. On a `ws_edge` into CHANNEL, clear the counter and go to SHIFT (the same discard-LSB rule as IDLE applies).

Conversion:
- take word[DATA_BITS-1 -: 8] (top 8 bits of the two's-complement word);
- invert bit 7 to get offset binary.
- Examples: 0x7F -> 0xFF, 0x80 -> 0x00, 0x00 -> 0x80, 0xFF -> 0x7F.

Latency and outputs:
- sample_out updates, and finished pulses high for exactly 1 clk, on the clk edge after the tick that captured bit DATA_BITS.
- From the pin sck rise of the last data bit to finished high: 4 clk, fixed.
- At most one finished per I2S frame.
- finished and frame_err are never high together.

Enable:
- en low: state forced to IDLE synchronously, counter cleared, no finished or frame_err pulses, sample_out holds its last value.
- en rising: capture restarts from IDLE, i.e. at the next ws edge into CHANNEL.

Boundary conditions:
- Reset mid-word: word discarded, outputs return to reset values, resync from IDLE.
- Unused slot bits beyond DATA_BITS are ignored.
- `ws_edge` on the same tick that would capture bit DATA_BITS counts as an early ws change: frame_err, no sample.
- Steady sck with ws stuck (no edges): no outputs ever.

Test Plan:
- Reset, en=1, CHANNEL=0, DATA_BITS=24, clk = 16x sck. Left words 0x7FFFFF, 0x800000, 0x000000, 0xFFFFFF -> sample_out 0xFF, 0x00, 0x80, 0x7F; exactly one 1-clk finished per frame, 4 clk after the last data-bit sck rise.
- Right slot carries 0x123456 while left carries 0x400000 -> sample_out 0xC0 only; the right data never appears.
- Enable mid-left-slot -> no sample for that partial frame; the first finished comes in the next complete left slot.
- Left slot truncated so ws toggles after 10 bits -> frame_err 1-clk pulse, no finished, sample_out keeps its prior value; the next full frame with 0x000000 gives 0x80.
- rst asserted mid-SHIFT -> immediately sample_out 0x80, finished 0; after release, the first full frame is captured correctly.
- en deasserted during SHIFT -> no finished for that frame, sample_out held; re-enable gives correct samples from the next left-slot start.

Source files
------------

// File: rtl/team_06_i2s_rx.sv
// I2S receiver: oversamples the mic pins in the clk domain and deserialises one
// channel slot into an 8-bit offset-binary sample with a one-clk finished strobe.
module team_06_i2s_rx #(
  parameter int DATA_BITS = 24,
  parameter bit CHANNEL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2s_sck,
  input  logic       i2s_ws,
  input  logic       i2s_sd,
  input  logic       en,
  output logic [7:0] sample_out,
  output logic       finished,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam int            CW       = 6;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BITS - 1);

  // Pin bundles are ordered {sck, ws, sd}
  logic [2:0]           r_meta;
  logic [2:0]           r_sync;
  logic                 r_sck_prev;
  logic                 r_ws_prev;
  state_t               r_state;
  state_t               w_state;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift;
  logic                 r_pend;
  logic                 w_pend;
  logic                 w_fin;
  logic                 w_ferr;
  logic [7:0]           w_sample;
  logic                 w_tick;
  logic                 w_ws_edge;

  function automatic logic [7:0] to_offset(input logic [DATA_BITS-1:0] word);
    logic [7:0] top;
    top = word[DATA_BITS-1 -: 8];
    return {~top[7], top[6:0]};
  endfunction

  // Two-flop synchronisers, sck edge history and ws value from the previous tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta     <= 3'b000;
      r_sync     <= 3'b000;
      r_sck_prev <= 1'b0;
      r_ws_prev  <= 1'b0;
    end else begin
      r_meta     <= {i2s_sck, i2s_ws, i2s_sd};
      r_sync     <= r_meta;
      r_sck_prev <= r_sync[2];
      if (w_tick) begin
        r_ws_prev <= r_sync[1];
      end
    end
  end

  assign w_tick    = r_sync[2] & ~r_sck_prev;
  assign w_ws_edge = w_tick & (r_sync[1] ^ r_ws_prev);

  // Next-state and output logic; a captured word is published one clk after its last bit
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_shift  = r_shift;
    w_pend   = 1'b0;
    w_fin    = 1'b0;
    w_ferr   = 1'b0;
    w_sample = sample_out;
    if (!en) begin
      w_state = S_IDLE;
      w_cnt   = {CW{1'b0}};
    end else begin
      if (r_pend) begin
        w_fin    = 1'b1;
        w_sample = to_offset(r_shift);
      end else begin
        w_fin = 1'b0;
      end
      case (r_state)
        S_IDLE, S_WAIT: begin
          if (w_ws_edge && (r_sync[1] == CHANNEL)) begin
            w_state = S_SHIFT;
            w_cnt   = {CW{1'b0}};
          end else begin
            w_state = r_state;
          end
        end
        S_SHIFT: begin
          if (w_ws_edge) begin
            w_ferr  = 1'b1;
            w_state = S_WAIT;
          end else if (w_tick) begin
            w_shift = {r_shift[DATA_BITS-2:0], r_sync[0]};
            w_cnt   = r_cnt + 6'd1;
            if (r_cnt == LAST_IDX) begin
              w_pend  = 1'b1;
              w_state = S_WAIT;
            end else begin
              w_state = S_SHIFT;
            end
          end else begin
            w_state = S_SHIFT;
          end
        end
        default: begin
          w_state = S_IDLE;
          w_cnt   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Receiver state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= {CW{1'b0}};
      r_shift    <= {DATA_BITS{1'b0}};
      r_pend     <= 1'b0;
      sample_out <= 8'd128;
      finished   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_shift    <= w_shift;
      r_pend     <= w_pend;
      sample_out <= w_sample;
      finished   <= w_fin;
      frame_err  <= w_ferr;
    end
  end

endmodule
